// File: rtl/mem_access_unit.sv
// Memory stage of the RV64 pipeline: issues loads/stores on a valid/ready data bus,
// aligns/extends load data, traps misaligned accesses and times out on silent responses.
module mem_access_unit #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_mem_op,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    output logic            req_wen,
    output logic [7:0]      req_wmask,
    output logic [XLEN-1:0] req_wdata,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_rdata,
    output logic            out_valid,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen,
    output logic [XLEN-1:0] out_rd_data,
    output logic            out_misalign,
    output logic            out_bus_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int NB = XLEN / 8;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   sdata_q, sdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              rd_wen_q, rd_wen_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              out_rd_wen_q, out_rd_wen_d;
    logic [XLEN-1:0]   out_rd_data_q, out_rd_data_d;
    logic              out_misalign_q, out_misalign_d;
    logic              out_bus_err_q, out_bus_err_d;

    logic [XLEN-1:0]   wdata_rep;
    logic [2:0]        lane_sel;
    logic [XLEN-1:0]   load_shifted;

    function automatic logic is_mem(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd11);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= 4'd8) && (op <= 4'd11);
    endfunction

    // log2 of the access size in bytes
    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            4'd2, 4'd6, 4'd9:  return 2'd1;
            4'd3, 4'd7, 4'd10: return 2'd2;
            4'd4, 4'd11:       return 2'd3;
            default:           return 2'd0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [2:0] off);
        case (op_size(op))
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            2'd3:    return |off;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [3:0] op, input logic [XLEN-1:0] d);
        case (op)
            4'd1:    return {{(XLEN-8){d[7]}}, d[7:0]};
            4'd2:    return {{(XLEN-16){d[15]}}, d[15:0]};
            4'd3:    return {{(XLEN-32){d[31]}}, d[31:0]};
            4'd5:    return {{(XLEN-8){1'b0}}, d[7:0]};
            4'd6:    return {{(XLEN-16){1'b0}}, d[15:0]};
            4'd7:    return {{(XLEN-32){1'b0}}, d[31:0]};
            default: return d;
        endcase
    endfunction

    // Each byte lane repeats the source byte at (lane mod access size).
    always_comb begin
        case (op_size(op_q))
            2'd0:    lane_sel = 3'd0;
            2'd1:    lane_sel = 3'd1;
            2'd2:    lane_sel = 3'd3;
            default: lane_sel = 3'd7;
        endcase
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [2:0] src;
        assign src = 3'(gi) & lane_sel;
        assign wdata_rep[8*gi +: 8] = sdata_q[{src, 3'b000} +: 8];
    end

    assign load_shifted = rsp_rdata >> {addr_q[2:0], 3'b000};

    assign in_ready  = (state_q == IDLE);
    assign req_valid = (state_q == REQ);
    assign req_wen   = req_valid && is_store(op_q);
    assign req_addr  = req_valid ? {addr_q[XLEN-1:3], 3'b000} : '0;
    assign req_wdata = req_wen ? wdata_rep : '0;

    always_comb begin
        req_wmask = 8'h00;
        if (req_wen) begin
            case (op_size(op_q))
                2'd0:    req_wmask = 8'h01 << addr_q[2:0];
                2'd1:    req_wmask = 8'h03 << addr_q[2:0];
                2'd2:    req_wmask = 8'h0F << addr_q[2:0];
                default: req_wmask = 8'hFF;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        sdata_d        = sdata_q;
        rd_d           = rd_q;
        rd_wen_d       = rd_wen_q;
        cnt_d          = cnt_q;
        out_valid_d    = 1'b0;
        out_rd_d       = '0;
        out_rd_wen_d   = 1'b0;
        out_rd_data_d  = '0;
        out_misalign_d = 1'b0;
        out_bus_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d     = in_mem_op;
                    addr_d   = in_alu_result;
                    sdata_d  = in_store_data;
                    rd_d     = in_rd;
                    rd_wen_d = in_rd_wen;
                    if (!is_mem(in_mem_op)) begin
                        state_d       = DONE;
                        out_valid_d   = 1'b1;
                        out_rd_d      = in_rd;
                        out_rd_wen_d  = in_rd_wen;
                        out_rd_data_d = in_alu_result;
                    end else if (misaligned(in_mem_op, in_alu_result[2:0])) begin
                        state_d        = DONE;
                        out_valid_d    = 1'b1;
                        out_rd_d       = in_rd;
                        out_misalign_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (req_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_rd_d    = rd_q;
                    if (!is_store(op_q)) begin
                        out_rd_wen_d  = rd_wen_q;
                        out_rd_data_d = load_extend(op_q, load_shifted);
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // this cycle's increment would reach TIMEOUT
                    state_d       = DONE;
                    out_valid_d   = 1'b1;
                    out_rd_d      = rd_q;
                    out_bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            op_q           <= '0;
            addr_q         <= '0;
            sdata_q        <= '0;
            rd_q           <= '0;
            rd_wen_q       <= 1'b0;
            cnt_q          <= '0;
            out_valid_q    <= 1'b0;
            out_rd_q       <= '0;
            out_rd_wen_q   <= 1'b0;
            out_rd_data_q  <= '0;
            out_misalign_q <= 1'b0;
            out_bus_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            sdata_q        <= sdata_d;
            rd_q           <= rd_d;
            rd_wen_q       <= rd_wen_d;
            cnt_q          <= cnt_d;
            out_valid_q    <= out_valid_d;
            out_rd_q       <= out_rd_d;
            out_rd_wen_q   <= out_rd_wen_d;
            out_rd_data_q  <= out_rd_data_d;
            out_misalign_q <= out_misalign_d;
            out_bus_err_q  <= out_bus_err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rd       = out_rd_q;
    assign out_rd_wen   = out_rd_wen_q;
    assign out_rd_data  = out_rd_data_q;
    assign out_misalign = out_misalign_q;
    assign out_bus_err  = out_bus_err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a spec-level model predicts bus requests and
// writeback results; a negedge monitor compares the DUT against it every cycle.
module tb_mem_access_unit;
    localparam int XLEN = 64;
    localparam int TO   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_mem_op;
    logic [XLEN-1:0] in_alu_result;
    logic [XLEN-1:0] in_store_data;
    logic [4:0]      in_rd;
    logic            in_rd_wen;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            req_wen;
    logic [7:0]      req_wmask;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            out_valid;
    logic [4:0]      out_rd;
    logic            out_rd_wen;
    logic [XLEN-1:0] out_rd_data;
    logic            out_misalign;
    logic            out_bus_err;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mem_op(in_mem_op),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .out_valid(out_valid), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
        .out_rd_data(out_rd_data), .out_misalign(out_misalign), .out_bus_err(out_bus_err)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] data;
        logic        mis;
        logic        err;
    } res_t;

    typedef struct packed {
        logic [63:0] addr;
        logic        wen;
        logic [7:0]  mask;
        logic [63:0] wdata;
    } req_t;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    req_t cur_req;
    bit   cur_req_ok = 1'b0;
    res_t ce;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            4'd1, 4'd5, 4'd8:  return 1;
            4'd2, 4'd6, 4'd9:  return 2;
            4'd3, 4'd7, 4'd10: return 4;
            4'd4, 4'd11:       return 8;
            default:           return 0;
        endcase
    endfunction

    // Writeback result from the architectural rules: truncate to n bytes, then
    // reinterpret as signed by subtracting 2^(8n) when the top bit is set.
    function automatic res_t model_res(input logic [3:0] op, input logic [63:0] addr,
                                       input logic [4:0] rd, input logic wen,
                                       input logic [63:0] rdata, input bit timed_out);
        res_t        r;
        int          n;
        int          o;
        logic [63:0] sh;
        logic [63:0] lim;
        r    = '0;
        r.rd = rd;
        n    = op_bytes(op);
        o    = int'(addr[2:0]);
        if (n == 0) begin
            r.wen  = wen;
            r.data = addr;
        end else if ((o % n) != 0) begin
            r.mis = 1'b1;
        end else if (timed_out) begin
            r.err = 1'b1;
        end else if (op < 4'd8) begin
            sh = rdata >> (8 * o);
            if (n < 8) begin
                lim = 64'd1 << (8 * n);
                sh  = sh % lim;
                if ((op == 4'd1 || op == 4'd2 || op == 4'd3) && sh >= (lim / 64'd2))
                    sh = sh - lim;
            end
            r.wen  = wen;
            r.data = sh;
        end
        return r;
    endfunction

    function automatic req_t model_req(input logic [3:0] op, input logic [63:0] addr,
                                       input logic [63:0] sdata);
        req_t q;
        int   n;
        int   o;
        q      = '0;
        n      = op_bytes(op);
        o      = int'(addr[2:0]);
        q.addr = addr - 64'(o);
        if (op >= 4'd8 && n != 0) begin
            q.wen = 1'b1;
            for (int b = 0; b < 8; b++) begin
                if (b >= o && b < o + n) q.mask[b] = 1'b1;
                q.wdata[8*b +: 8] = sdata[8*(b % n) +: 8];
            end
        end
        return q;
    endfunction

    // Per-cycle monitor against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0");
                end else begin
                    ce = exp_q.pop_front();
                    chk("out_rd",       64'(out_rd),       64'(ce.rd));
                    chk("out_rd_wen",   64'(out_rd_wen),   64'(ce.wen));
                    chk("out_rd_data",  out_rd_data,       ce.data);
                    chk("out_misalign", 64'(out_misalign), 64'(ce.mis));
                    chk("out_bus_err",  64'(out_bus_err),  64'(ce.err));
                end
            end else begin
                chk("quiet_data",  out_rd_data, 64'd0);
                chk("quiet_flags", 64'({out_rd, out_rd_wen, out_misalign, out_bus_err}), 64'd0);
            end
            if (req_valid) begin
                if (!cur_req_ok) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req_valid: got 1 expected 0");
                end else begin
                    chk("req_addr",  req_addr,         cur_req.addr);
                    chk("req_wen",   64'(req_wen),     64'(cur_req.wen));
                    chk("req_wmask", 64'(req_wmask),   64'(cur_req.mask));
                    chk("req_wdata", req_wdata,        cur_req.wdata);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] sdata,
                         input logic [4:0] rd, input logic wen);
        bit ok;
        int n;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL in_ready_wait: got 0 expected 1");
        end
        n          = op_bytes(op);
        cur_req    = model_req(op, addr, sdata);
        cur_req_ok = 1'b0;
        if (n != 0) cur_req_ok = ((int'(addr[2:0]) % n) == 0);
        if (!cur_req_ok) exp_q.push_back(model_res(op, addr, rd, wen, 64'd0, 1'b0));
        in_valid      = 1'b1;
        in_mem_op     = op;
        in_alu_result = addr;
        in_store_data = sdata;
        in_rd         = rd;
        in_rd_wen     = wen;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_mem_op = 4'd0;
    endtask

    task automatic mem_txn(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] sdata,
                           input logic [4:0] rd, input logic wen, input int ready_delay,
                           input int rsp_delay, input logic [63:0] rdata, input bit respond,
                           input bit junk);
        issue(op, addr, sdata, rd, wen);
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            chk("req_held", 64'(req_valid), 64'd1);
            if (junk) begin
                in_valid      = 1'b1;
                in_mem_op     = 4'd0;
                in_alu_result = 64'hDEAD;
                in_rd         = 5'd9;
            end
        end
        @(negedge clk);
        chk("req_valid", 64'(req_valid), 64'd1);
        in_valid  = 1'b0;
        req_ready = 1'b1;
        @(posedge clk);
        #1;
        req_ready = 1'b0;
        if (respond) begin
            for (int i = 0; i < rsp_delay; i++) begin
                @(negedge clk);
                chk("wait_no_out", 64'(out_valid), 64'd0);
            end
            @(negedge clk);
            rsp_valid = 1'b1;
            rsp_rdata = rdata;
            exp_q.push_back(model_res(op, addr, rd, wen, rdata, 1'b0));
            @(posedge clk);
            #1;
            rsp_valid = 1'b0;
            @(negedge clk);
            chk("rsp_latency", 64'(out_valid), 64'd1);
        end else begin
            exp_q.push_back(model_res(op, addr, rd, wen, 64'd0, 1'b1));
            for (int i = 0; i < TO; i++) begin
                @(negedge clk);
                chk("timeout_early", 64'(out_valid), 64'd0);
            end
            @(negedge clk);
            chk("timeout_latency", 64'(out_valid), 64'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t m;
        req_t q;
        rst = 1'b1; in_valid = 1'b0; in_mem_op = 4'd0; in_alu_result = '0;
        in_store_data = '0; in_rd = '0; in_rd_wen = 1'b0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_rdata = '0;

        // Hand-computed pins on the model itself
        m = model_res(4'd1, 64'h1003, 5'd7, 1'b1, 64'h0000_0000_8000_0000, 1'b0);
        chk("pin_lb", m.data, 64'hFFFF_FFFF_FFFF_FF80);
        m = model_res(4'd5, 64'h1003, 5'd7, 1'b1, 64'h0000_0000_8000_0000, 1'b0);
        chk("pin_lbu", m.data, 64'h80);
        m = model_res(4'd7, 64'h4004, 5'd3, 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b0);
        chk("pin_lwu", m.data, 64'h0000_0000_FFFF_FFFF);
        q = model_req(4'd9, 64'h2006, 64'hBEEF);
        chk("pin_sh_mask", 64'(q.mask), 64'hC0);
        chk("pin_sh_wdata", q.wdata, 64'hBEEF_BEEF_BEEF_BEEF);
        chk("pin_sh_addr", q.addr, 64'h2000);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready",  64'(in_ready),  64'd1);
        chk("reset_req_valid", 64'(req_valid), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;

        // Passthrough, latency 1
        issue(4'd0, 64'h1234, 64'd0, 5'd5, 1'b1);
        @(negedge clk);
        chk("pass_latency", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("pass_back_idle", 64'(in_ready), 64'd1);

        // Loads
        mem_txn(4'd1, 64'h1003, 64'd0, 5'd7, 1'b1, 0, 0, 64'h0000_0000_8000_0000, 1'b1, 1'b0);
        mem_txn(4'd5, 64'h1003, 64'd0, 5'd7, 1'b1, 1, 1, 64'h0000_0000_8000_0000, 1'b1, 1'b0);
        mem_txn(4'd2, 64'h1006, 64'd0, 5'd8, 1'b1, 0, 2, 64'h8001_0000_0000_0000, 1'b1, 1'b0);
        mem_txn(4'd6, 64'h1006, 64'd0, 5'd8, 1'b1, 0, 0, 64'h8001_0000_0000_0000, 1'b1, 1'b0);
        mem_txn(4'd3, 64'h1004, 64'd0, 5'd9, 1'b1, 0, 0, 64'h7FFF_FFFF_0000_0000, 1'b1, 1'b0);
        mem_txn(4'd3, 64'h1000, 64'd0, 5'd9, 1'b1, 0, 0, 64'h0000_0000_9234_5678, 1'b1, 1'b0);
        mem_txn(4'd4, 64'h1008, 64'd0, 5'd10, 1'b1, 0, 0, 64'hA5A5_0123_4567_89AB, 1'b1, 1'b0);
        mem_txn(4'd5, 64'h1007, 64'd0, 5'd11, 1'b0, 0, 0, 64'hFE00_0000_0000_0000, 1'b1, 1'b0);

        // Stores, with backpressure and ignored in_valid while busy
        mem_txn(4'd9, 64'h2006, 64'hBEEF, 5'd12, 1'b1, 3, 2, 64'hFFFF, 1'b1, 1'b1);
        @(negedge clk);
        chk("sh_in_ready", 64'(in_ready), 64'd1);
        mem_txn(4'd11, 64'h2000, 64'h0123_4567_89AB_CDEF, 5'd1, 1'b1, 0, 0, 64'd0, 1'b1, 1'b0);
        mem_txn(4'd8, 64'h2005, 64'h1234_56A5, 5'd2, 1'b1, 1, 0, 64'd0, 1'b1, 1'b0);
        mem_txn(4'd10, 64'h2004, 64'hCAFE_F00D, 5'd3, 1'b1, 0, 1, 64'd0, 1'b1, 1'b0);

        // Misaligned accesses, no bus request
        issue(4'd3, 64'h3002, 64'd0, 5'd4, 1'b1);
        @(negedge clk);
        chk("mis_lw_latency", 64'(out_valid), 64'd1);
        issue(4'd11, 64'h2004, 64'h55, 5'd4, 1'b1);
        @(negedge clk);
        chk("mis_sd_latency", 64'(out_valid), 64'd1);
        issue(4'd9, 64'h2001, 64'h55, 5'd4, 1'b1);
        @(negedge clk);
        chk("mis_sh_latency", 64'(out_valid), 64'd1);
        issue(4'd13, 64'hABCD, 64'd0, 5'd6, 1'b0);
        @(negedge clk);
        chk("op13_latency", 64'(out_valid), 64'd1);

        // Timeout, then a late response in IDLE
        mem_txn(4'd4, 64'h5000, 64'd0, 5'd13, 1'b1, 0, 0, 64'd0, 1'b0, 1'b0);
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_rdata = 64'h1111;
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_rsp_ignored", 64'(out_valid), 64'd0);
        end
        chk("late_rsp_in_ready", 64'(in_ready), 64'd1);

        // Reset during REQ
        issue(4'd11, 64'h6000, 64'h77, 5'd14, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_drop", 64'(req_valid), 64'd0);
        chk("rst_req_ready", 64'(in_ready), 64'd1);

        // Reset during WAIT, then an LWU
        issue(4'd4, 64'h5008, 64'd0, 5'd15, 1'b1);
        @(negedge clk);
        req_ready = 1'b1;
        @(posedge clk);
        #1;
        req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wait_req",  64'(req_valid), 64'd0);
        chk("rst_wait_out",  64'(out_valid), 64'd0);
        chk("rst_wait_rdy",  64'(in_ready),  64'd1);
        mem_txn(4'd7, 64'h4004, 64'd0, 5'd3, 1'b1, 0, 0, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage of the 5-stage RV64 pipeline; sits between the execute stage and writeback.
- Takes the execute result (ALU result used as effective address, forwarded rs2 data as store data) and performs loads and stores on the data-memory bus with a valid/ready request and response protocol.
- Aligns and extends load data, builds store byte masks, detects misalignment and bus timeout.
- Stalls the upstream pipeline while a transaction is outstanding.

Parameters:
- XLEN, 64, datapath and address width.
- TIMEOUT, 255, maximum cycles to wait for rsp_valid after a request handshake.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  unit can accept; equals (state==IDLE)
- in_mem_op  in  4  0 none, 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU, 8 SB, 9 SH, 10 SW, 11 SD; 12-15 treated as none
- in_alu_result  in  XLEN  effective address, or passthrough result
- in_store_data  in  XLEN  forwarded rs2 value
- in_rd  in  5  destination register
- in_rd_wen  in  1  destination write enable
- req_valid  out  1  memory request valid
- req_ready  in  1  memory accepts request
- req_addr  out  XLEN  8-byte-aligned address, {addr[63:3],3'b0}
- req_wen  out  1  1 = store
- req_wmask  out  8  byte enables; stores only, 0 for loads
- req_wdata  out  XLEN  lane-replicated store data
- rsp_valid  in  1  response or store acknowledge
- rsp_rdata  in  XLEN  aligned 8-byte read data
- out_valid  out  1  one-cycle pulse to writeback
- out_rd  out  5  destination register
- out_rd_wen  out  1  register write enable
- out_rd_data  out  XLEN  load result or passthrough
- out_misalign  out  1  misaligned access trapped
- out_bus_err  out  1  response timeout

Behaviour:
- Reset (rst, synchronous, active-high): state IDLE, timeout counter 0, all outputs 0 except in_ready=1. rst mid-transaction drops req_valid the next cycle. Any late rsp_valid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, on in_valid, latches all inputs:
  - op none: go to DONE; out_rd_data = in_alu_result; rd_wen passed through. Latency is 1 cycle.
  - Misaligned op: go to DONE with out_misalign=1, out_rd_wen=0; no bus request is issued. Misaligned means H with addr[0]≠0, W with addr[1:0]≠0, D with addr[2:0]≠0.
  - Aligned memory op: go to REQ.
- REQ: req_valid=1 with address, mask and data held stable until req_ready. On handshake, go to WAIT and clear the counter. rsp_valid is ignored in REQ.
- WAIT:
  - On rsp_valid: capture rsp_rdata and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to DONE with out_bus_err=1 and out_rd_wen=0.
  - The earliest response is 1 cycle after the handshake.
- DONE: out_valid=1 for exactly one cycle, then go to IDLE. Outputs are registered and return to 0 when out_valid=0.
- Stores: out_rd_wen=0; the response acts only as an acknowledge. Byte offset o = addr[2:0].
  - SB: mask 8'h01<<o, wdata {8{d[7:0]}}.
  - SH: mask 8'h03<<o, wdata {4{d[15:0]}}.
  - SW: mask 8'h0F<<o, wdata {2{d[31:0]}}.
  - SD: mask 8'hFF, wdata d.
- Loads: shifted = rsp_rdata >> (o*8).
  - LB, LH, LW sign-extend from bit 7, 15, 31.
  - LBU, LHU, LWU zero-extend.
  - LD uses shifted unchanged.
  - out_rd_wen = latched in_rd_wen.
- in_valid is ignored while in_ready=0. The upstream stage holds the instruction, since in_ready drives the pipeline stall.
- Throughput: one non-memory op every 2 cycles (IDLE→DONE→IDLE). A memory op takes at least 4 cycles.

Test Plan:
- Passthrough: mem_op=0, alu_result=0x1234, rd=5, wen=1 → out_valid 1 cycle later; rd_data=0x1234, rd=5, rd_wen=1; req_valid never asserted.
- LB sign extension: addr=0x1003, rsp_rdata=0x00000000_80000000 → req_addr=0x1000, req_wmask=0; out_rd_data=0xFFFF_FFFF_FFFF_FF80. Repeat with LBU → 0x80.
- SH with backpressure: addr=0x2006, data=0xBEEF, req_ready low for 3 cycles → req fields stable all 3 cycles; wmask=0xC0, wdata=0xBEEF_BEEF_BEEF_BEEF; after ack, out_rd_wen=0 and in_ready returns to 1.
- Misaligned LW: addr=0x3002 → no req_valid; out_valid next cycle with out_misalign=1, rd_wen=0.
- Timeout: TIMEOUT=4, LD accepted, rsp_valid never asserted → out_bus_err=1 exactly 4 cycles after the handshake; a rsp_valid arriving afterwards in IDLE is ignored.
- Reset mid-WAIT: rst asserted one cycle in WAIT → next cycle req_valid=0, out_valid=0, in_ready=1; a following LWU at 0x4004 with rdata 0xFFFFFFFF_00000000 → out_rd_data=0x00000000_FFFFFFFF.
